// File: rtl/sm_block_accumulator.sv
// sm_block_accumulator
//   Collects COUNT sign-magnitude sums from the upstream adder stage,
//   accumulates them in two's complement, converts the block total back to
//   sign-magnitude with saturation to OUT_W bits, and holds the result on a
//   valid/ready output port until the consumer takes it.
//
//   Optional feature: define SMACC_FLUSH_EN to add the flush input, which
//   closes a partial block early.
module sm_block_accumulator #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 8,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
`ifdef SMACC_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  // Accumulator is wide enough for COUNT full-scale inputs of either sign,
  // so it can never wrap.
  localparam int ACC_W = IN_W + $clog2(COUNT) + 1;
  localparam int CNT_W = $clog2(COUNT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  // Saturation compare is done at the wider of the accumulator and output
  // widths so that neither side is truncated.
  localparam int CMP_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic [CMP_W-1:0] MAG_MAX_W =
    {{(CMP_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};

  typedef enum logic [1:0] {
    ST_ACC,
    ST_CONVERT,
    ST_HOLD
  } state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;
  logic        [OUT_W-1:0]   out_data_q, out_data_d;
  logic                      out_ovf_q, out_ovf_d;

  logic                      beat;
  logic                      flush_go;
  logic        [ACC_W-1:0]   in_mag_ext;
  logic signed [ACC_W-1:0]   in_value;
  logic                      acc_neg;
  logic        [ACC_W-1:0]   acc_abs;
  logic        [CMP_W-1:0]   abs_w;
  logic                      sat;
  logic        [OUT_W-2:0]   mag_sat;
  logic        [OUT_W-1:0]   cnv_data;

  // Handshake and status outputs are decoded from registered state only.
  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = (cnt_q != '0) || (state_q != ST_ACC);
  assign beat      = in_valid && in_ready;

`ifdef SMACC_FLUSH_EN
  // A flush only means something if there is data to close the block with.
  assign flush_go = flush && ((cnt_q != '0) || beat);
`else
  assign flush_go = 1'b0;
`endif

  // Decode the incoming sign-magnitude sum; negative zero becomes plain 0.
  always_comb begin
    in_mag_ext = {{(ACC_W - IN_W + 1){1'b0}}, in_data[IN_W-2:0]};
    in_value   = in_data[IN_W-1] ? -$signed(in_mag_ext) : $signed(in_mag_ext);
  end

  // Convert the block total to sign-magnitude with saturation. A zero total
  // has a clear sign bit because acc_neg is just the accumulator MSB.
  always_comb begin
    acc_neg  = acc_q[ACC_W-1];
    acc_abs  = acc_neg ? ACC_W'(-acc_q) : ACC_W'(acc_q);
    abs_w    = CMP_W'(acc_abs);
    sat      = (abs_w > MAG_MAX_W);
    mag_sat  = sat ? MAG_MAX_W[OUT_W-2:0] : abs_w[OUT_W-2:0];
    cnv_data = {acc_neg, mag_sat};
  end

  // Next-state and datapath update for the ACC -> CONVERT -> HOLD cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;

    unique case (state_q)
      ST_ACC: begin
        if (beat) begin
          acc_d = acc_q + in_value;
          cnt_d = cnt_q + CNT_W'(1);
        end
        if ((beat && (cnt_q == LAST_CNT)) || flush_go) begin
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        out_data_d = cnv_data;
        out_ovf_d  = sat;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        // No bypass: the next block may only start after the result is taken.
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_ACC;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial or pending block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ACC;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_sm_block_accumulator.sv
// tb_sm_block_accumulator
//   Directed self-checking bench for sm_block_accumulator. A second instance
//   with OUT_W=6 runs in lockstep to exercise output saturation.
//   Define SMACC_FLUSH_EN to also exercise the flush input.
module tb_sm_block_accumulator;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [5:0] in_data;
  logic       out_ready;
  logic       flush;

  logic       in_ready,  out_valid,  out_ovf,  busy;
  logic [7:0] out_data;
  logic       in_ready6, out_valid6, out_ovf6, busy6;
  logic [5:0] out_data6;

  int pass_cnt  = 0;
  int total_cnt = 0;

  sm_block_accumulator #(.IN_W(6), .OUT_W(8), .COUNT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
`ifdef SMACC_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  sm_block_accumulator #(.IN_W(6), .OUT_W(6), .COUNT(4)) dut6 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready6),
    .in_data   (in_data),
    .out_valid (out_valid6),
    .out_ready (out_ready),
    .out_data  (out_data6),
    .out_ovf   (out_ovf6),
    .busy      (busy6)
`ifdef SMACC_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one beat and let it be sampled on the next rising edge.
  task automatic drive_beat(input logic [5:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
  endtask

  // Called right after the edge of the last beat: observe the CONVERT cycle,
  // the first HOLD cycle, then take the result.
  task automatic collect(output logic v1, output logic r1, output logic v2,
                         output logic [7:0] d, output logic o,
                         output logic [5:0] d6, output logic o6);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 6'h1f;
    flush    = 1'b0;
    v1 = out_valid;
    r1 = in_ready;
    @(negedge clk);
    v2 = out_valid;
    d  = out_data;
    o  = out_ovf;
    d6 = out_data6;
    o6 = out_ovf6;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total_cnt++;
    if ({in_ready, out_valid, out_data, out_ovf, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0})
      $display("FAIL reset_state: got rdy=%b vld=%b data=%h ovf=%b busy=%b, expected rdy=1 vld=0 data=00 ovf=0 busy=0",
               in_ready, out_valid, out_data, out_ovf, busy);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({in_ready, out_valid, busy} !== 3'b100)
      $display("FAIL reset_release: got rdy=%b vld=%b busy=%b, expected 1 0 0", in_ready, out_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic v1, r1, v2, o, o6;
    logic [7:0] d;
    logic [5:0] d6;
    drive_beat(6'b000101);
    drive_beat(6'b000011);
    drive_beat(6'b100010);
    drive_beat(6'b000000);
    collect(v1, r1, v2, d, o, d6, o6);
    total_cnt++;
    if ({v1, r1} !== 2'b00)
      $display("FAIL basic_convert_cycle: got vld=%b rdy=%b, expected vld=0 rdy=0", v1, r1);
    else pass_cnt++;
    total_cnt++;
    if ({v2, d, o} !== {1'b1, 8'h06, 1'b0})
      $display("FAIL basic_result: got vld=%b data=%h ovf=%b, expected vld=1 data=06 ovf=0", v2, d, o);
    else pass_cnt++;
    total_cnt++;
    if ({d6, o6} !== {6'h06, 1'b0})
      $display("FAIL basic_result_w6: got data=%h ovf=%b, expected data=06 ovf=0", d6, o6);
    else pass_cnt++;
    total_cnt++;
    if ({in_ready, out_valid, busy} !== 3'b100)
      $display("FAIL basic_after_take: got rdy=%b vld=%b busy=%b, expected 1 0 0", in_ready, out_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    logic v1, r1, v2, o, o6;
    logic [7:0] d;
    logic [5:0] d6;
    for (int i = 0; i < 4; i++) drive_beat(6'b111111);
    collect(v1, r1, v2, d, o, d6, o6);
    total_cnt++;
    if ({v2, d, o} !== {1'b1, 8'hFC, 1'b0})
      $display("FAIL neg124_w8: got vld=%b data=%h ovf=%b, expected vld=1 data=fc ovf=0", v2, d, o);
    else pass_cnt++;
    total_cnt++;
    if ({d6, o6} !== {6'b111111, 1'b1})
      $display("FAIL neg124_w6_sat: got data=%b ovf=%b, expected data=111111 ovf=1", d6, o6);
    else pass_cnt++;
  endtask

  task automatic test_neg_zero();
    logic v1, r1, v2, o, o6;
    logic [7:0] d;
    logic [5:0] d6;
    for (int i = 0; i < 4; i++) drive_beat(6'b100000);
    collect(v1, r1, v2, d, o, d6, o6);
    total_cnt++;
    if ({v2, d, o} !== {1'b1, 8'h00, 1'b0})
      $display("FAIL neg_zero: got vld=%b data=%h ovf=%b, expected vld=1 data=00 ovf=0", v2, d, o);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic v1, r1, v2, o, o6;
    logic [7:0] d;
    logic [5:0] d6;
    drive_beat(6'd1);
    drive_beat(6'd2);
    drive_beat(6'd3);
    drive_beat(6'd4);
    // Source immediately offers the first beat of the next block (+9) and holds it.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 6'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({out_valid, out_data, out_ovf, in_ready} !== {1'b1, 8'h0A, 1'b0, 1'b0})
        $display("FAIL hold_stable_%0d: got vld=%b data=%h ovf=%b rdy=%b, expected vld=1 data=0a ovf=0 rdy=0",
                 i, out_valid, out_data, out_ovf, in_ready);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    // Beat was offered throughout HOLD and must not have been counted.
    total_cnt++;
    if ({in_ready, out_valid, busy} !== 3'b100)
      $display("FAIL hold_beat_not_taken: got rdy=%b vld=%b busy=%b, expected 1 0 0", in_ready, out_valid, busy);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({in_ready, busy} !== 2'b11)
      $display("FAIL held_beat_taken: got rdy=%b busy=%b, expected 1 1", in_ready, busy);
    else pass_cnt++;
    in_data = 6'd1;
    @(posedge clk);
    drive_beat(6'd1);
    drive_beat(6'd1);
    collect(v1, r1, v2, d, o, d6, o6);
    total_cnt++;
    if ({v2, d, o} !== {1'b1, 8'h0C, 1'b0})
      $display("FAIL after_backpressure: got vld=%b data=%h ovf=%b, expected vld=1 data=0c ovf=0", v2, d, o);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int t[3];
    int n;
    logic prev;
    n = 0;
    prev = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 6'd2;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge clk);
      if (out_valid && !prev) begin
        t[n] = c;
        total_cnt++;
        if ({out_data, out_ovf} !== {8'h08, 1'b0})
          $display("FAIL b2b_data_%0d: got data=%h ovf=%b, expected data=08 ovf=0", n, out_data, out_ovf);
        else pass_cnt++;
        n++;
      end
      prev = out_valid;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total_cnt++;
    if (n !== 3)
      $display("FAIL b2b_results: got %0d results in 40 cycles, expected 3", n);
    else pass_cnt++;
    if (n == 3) begin
      total_cnt++;
      if ((t[1] - t[0]) !== 6 || (t[2] - t[1]) !== 6)
        $display("FAIL b2b_period: got %0d and %0d cycles, expected 6 and 6", t[1] - t[0], t[2] - t[1]);
      else pass_cnt++;
    end
    apply_reset();
  endtask

  task automatic test_reset_midblock();
    logic v1, r1, v2, o, o6;
    logic [7:0] d;
    logic [5:0] d6;
    drive_beat(6'd7);
    drive_beat(6'd7);
    @(negedge clk);
    in_valid = 1'b0;
    total_cnt++;
    if (busy !== 1'b1)
      $display("FAIL midblock_busy: got busy=%b, expected 1", busy);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({in_ready, out_valid, busy} !== 3'b100)
      $display("FAIL async_reset: got rdy=%b vld=%b busy=%b, expected 1 0 0", in_ready, out_valid, busy);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive_beat(6'd1);
    collect(v1, r1, v2, d, o, d6, o6);
    total_cnt++;
    if ({v1, v2, d, o} !== {1'b0, 1'b1, 8'h04, 1'b0})
      $display("FAIL after_reset_block: got vld1=%b vld2=%b data=%h ovf=%b, expected 0 1 04 0", v1, v2, d, o);
    else pass_cnt++;
    total_cnt++;
    if ({d6, o6} !== {6'h04, 1'b0})
      $display("FAIL after_reset_block_w6: got data=%h ovf=%b, expected data=04 ovf=0", d6, o6);
    else pass_cnt++;
  endtask

`ifdef SMACC_FLUSH_EN
  task automatic test_flush();
    logic v1, r1, v2, o, o6;
    logic [7:0] d;
    logic [5:0] d6;
    drive_beat(6'd7);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 6'b100011;
    flush    = 1'b1;
    @(posedge clk);
    collect(v1, r1, v2, d, o, d6, o6);
    total_cnt++;
    if ({v2, d, o} !== {1'b1, 8'h04, 1'b0})
      $display("FAIL flush_partial: got vld=%b data=%h ovf=%b, expected vld=1 data=04 ovf=0", v2, d, o);
    else pass_cnt++;
    // Idle flush with an empty block is ignored.
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total_cnt++;
    if ({in_ready, busy} !== 2'b10)
      $display("FAIL flush_idle: got rdy=%b busy=%b, expected 1 0", in_ready, busy);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) drive_beat(6'd1);
    @(negedge clk);
    in_valid = 1'b0;
    total_cnt++;
    if ({in_ready, busy, out_valid} !== 3'b110)
      $display("FAIL flush_fresh_block: got rdy=%b busy=%b vld=%b, expected 1 1 0", in_ready, busy, out_valid);
    else pass_cnt++;
    drive_beat(6'd1);
    collect(v1, r1, v2, d, o, d6, o6);
    total_cnt++;
    if ({v2, d, o} !== {1'b1, 8'h04, 1'b0})
      $display("FAIL flush_next_block: got vld=%b data=%h ovf=%b, expected vld=1 data=04 ovf=0", v2, d, o);
    else pass_cnt++;
  endtask
`endif

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 6'h00;
    out_ready = 1'b0;
    flush     = 1'b0;
    test_reset();
    test_basic();
    test_saturate();
    test_neg_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_midblock();
`ifdef SMACC_FLUSH_EN
    test_flush();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
